expr_checker: RTL and testbench
===============================

// Module: expr_checker
// PURPOSE
//  Downstream consumer of the ASCII character classifier stage. Takes one ASCII byte
//  per accepted cycle and tracks whether the stream so far forms a legal expression
//  of the form D ((+|*) D)*, where D is a single decimal digit.
//  Reports legality, a sticky error and an operator count to the debug/display logic.
//  Optionally evaluates the expression with * binding tighter than +.
// PARAMETERS
//  CNT_W  8   width of op_cnt; saturating
//  VAL_W  16  width of value; arithmetic wraps modulo 2^VAL_W (EXPR_EVAL_EN only)
// PORTS
//  clk       in   1      rising-edge clock
//  rst_n     in   1      asynchronous active-low reset
//  in_valid  in   1      in carries a character this cycle
//  in        in   8      ASCII character
//  clr       in   1      synchronous restart to empty expression
//  legal     out  1      stream so far is a complete legal expression
//  err       out  1      sticky: illegal character or sequence seen since clear
//  op_cnt    out  CNT_W  number of + and * accepted since clear
//  value     out  VAL_W  value of the expression so far (EXPR_EVAL_EN only)
// BEHAVIOUR
//  - One clock domain. Reset is asynchronous and active-low.
//  - Reset (rst_n=0): state=S_EMPTY; legal=0, err=0, op_cnt=0, value=0, sum=0, term=0.
//  - Classes: DIG = "0".."9", OP = "+" or "*", BAD = any other byte.
//  - FSM; all outputs are registered and reflect a character 1 cycle after acceptance.
//    S_EMPTY: DIG->S_NUM; OP->S_ERR; BAD->S_ERR
//    S_NUM  : OP->S_OP (op_cnt++); DIG->S_ERR (multi-digit operand); BAD->S_ERR
//    S_OP   : DIG->S_NUM; OP->S_ERR; BAD->S_ERR
//    S_ERR  : absorbing; leaves only on clr or reset
//  - legal = (state==S_NUM); err = (state==S_ERR).
//  - in_valid=0: no state, counter or value change.
//  - clr=1: next state S_EMPTY, all outputs 0. Has priority over a simultaneous in_valid;
//    that character is dropped.
//  - op_cnt saturates at 2^CW-1 and never wraps. It freezes in S_ERR.
//  - Reset asserted mid-expression clears immediately, regardless of clk.
// CONFIGURATION
//  EXPR_EVAL_EN defined: keeps a sum register and a term register, and drives value.
//    - DIG from S_EMPTY or after "+": term <= d.
//    - DIG after "*": term <= term*d, truncated to VAL_W.
//    - "+": sum <= sum+term.
//    - value = sum+term, registered; wraps modulo 2^VAL_W.
//    - In S_ERR, value holds its last legal-path value.
//  EXPR_EVAL_EN undefined: no arithmetic registers; value port is absent.
// STRUCTURE
//  - Package expr_pkg: state enum (S_EMPTY, S_NUM, S_OP, S_ERR); ASCII constants for
//    "0", "9", "+", "*"; char-class enum (C_DIG, C_OP, C_BAD).
//  - Sub-module expr_char_class: combinational byte -> {class, is_mul, digit[3:0]}.
//    Instantiated once.
//  - Top level: FSM, saturating counter, optional evaluator.
// TESTING
//  1. "1","+","2","*","3" one char/cycle -> legal=1, err=0, op_cnt=2, value=7 after last.
//  2. "7","*" -> legal=0 after "*", err=0; then "+" -> err=1 and stays 1 for further chars.
//  3. "1","2" -> err=1 on the 2nd char; clr pulse -> legal=0, err=0, op_cnt=0 next cycle.
//  4. Drive "a" (0x61) first -> err=1. Idle cycles with in_valid=0 and in="+" -> no change.
//  5. clr and in_valid ("5") in the same cycle -> S_EMPTY, legal=0 (char dropped).
//  6. 260 pairs of "1","+" with CNT_W=8 -> op_cnt holds at 255. Mid-stream rst_n=0
//     between clock edges -> all outputs 0 at once.

Source files
------------

// File: rtl/expr_pkg.sv
// Shared types and constants for the expression checker.
package expr_pkg;

  typedef enum logic [1:0] {S_EMPTY, S_NUM, S_OP, S_ERR} state_t;
  typedef enum logic [1:0] {C_DIG, C_OP, C_BAD} cls_t;

  localparam logic [7:0] CH_0    = 8'h30;
  localparam logic [7:0] CH_9    = 8'h39;
  localparam logic [7:0] CH_PLUS = 8'h2B;
  localparam logic [7:0] CH_MUL  = 8'h2A;

endpackage

// File: rtl/expr_char_class.sv
// Combinational ASCII byte classifier: digit / operator / other.
module expr_char_class
  import expr_pkg::*;
(
  input  logic [7:0] ch,
  output cls_t       cls,
  output logic       is_mul,
  output logic [3:0] digit
);

  // Decode class; digit value is the low nibble of "0".."9".
  always_comb begin
    cls    = C_BAD;
    is_mul = 1'b0;
    digit  = 4'd0;
    if (ch >= CH_0 && ch <= CH_9) begin
      cls   = C_DIG;
      digit = ch[3:0];
    end else if (ch == CH_PLUS) begin
      cls = C_OP;
    end else if (ch == CH_MUL) begin
      cls    = C_OP;
      is_mul = 1'b1;
    end
  end

endmodule

// File: rtl/expr_checker.sv
// Streaming checker for expressions D ((+|*) D)*.
// Define EXPR_EVAL_EN to add the evaluator and the value port
// (* binds tighter than +, arithmetic wraps modulo 2^VAL_W).
module expr_checker
  import expr_pkg::*;
#(
  parameter int CNT_W = 8,
  parameter int VAL_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [7:0]       in,
  input  logic             clr,
  output logic             legal,
  output logic             err,
`ifdef EXPR_EVAL_EN
  output logic [VAL_W-1:0] value,
`endif
  output logic [CNT_W-1:0] op_cnt
);

  state_t     state, state_n;
  cls_t       cls;
  logic       is_mul;
  logic [3:0] digit;
  logic       acc;
  logic       op_ok;
  logic       dig_ok;

  expr_char_class u_cls (
    .ch     (in),
    .cls    (cls),
    .is_mul (is_mul),
    .digit  (digit)
  );

  assign acc   = in_valid & ~clr;
  assign legal = (state == S_NUM);
  assign err   = (state == S_ERR);

  // Next-state: grammar walk, clr wins over any character this cycle.
  always_comb begin
    state_n = state;
    op_ok   = 1'b0;
    dig_ok  = 1'b0;
    if (clr) begin
      state_n = S_EMPTY;
    end else if (in_valid) begin
      case (state)
        S_EMPTY, S_OP: begin
          if (cls == C_DIG) begin
            state_n = S_NUM;
            dig_ok  = 1'b1;
          end else begin
            state_n = S_ERR;
          end
        end
        S_NUM: begin
          if (cls == C_OP) begin
            state_n = S_OP;
            op_ok   = 1'b1;
          end else begin
            state_n = S_ERR;
          end
        end
        default: state_n = S_ERR;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_EMPTY;
    else        state <= state_n;
  end

  // Saturating operator counter; only legal operators reach it, so it freezes in S_ERR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         op_cnt <= '0;
    else if (clr)                       op_cnt <= '0;
    else if (op_ok && (op_cnt != '1))   op_cnt <= op_cnt + 1'b1;
  end

`ifdef EXPR_EVAL_EN
  logic [VAL_W-1:0] sum, term, term_n;
  logic             mul_pend;

  // New term: restart on a digit after "+"/empty, extend the product after "*".
  always_comb begin
    term_n = VAL_W'(digit);
    if (mul_pend) term_n = term * VAL_W'(digit);
  end

  // Evaluator: sum holds all closed products, term the open product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum <= '0; term <= '0; value <= '0; mul_pend <= 1'b0;
    end else if (clr) begin
      sum <= '0; term <= '0; value <= '0; mul_pend <= 1'b0;
    end else if (acc && dig_ok) begin
      term  <= term_n;
      value <= sum + term_n;
    end else if (acc && op_ok) begin
      mul_pend <= is_mul;
      if (!is_mul) sum <= sum + term;
    end
  end
`else
  localparam int unused_val_w = VAL_W;
  logic unused_eval;
  assign unused_eval = ^{is_mul, digit, acc, dig_ok};
`endif

endmodule

// File: tb/tb_expr_checker.sv
// Randomized + directed bench for expr_checker against a string-level reference model.
module tb_expr_checker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_ch = 8'h00;
  logic        clr = 1'b0;
  logic        legal, err;
  logic [7:0]  op_cnt;
`ifdef EXPR_EVAL_EN
  logic [15:0] value;
`endif

  int total = 0;
  int bad   = 0;
  byte unsigned q[$];

  expr_checker #(.CNT_W(8), .VAL_W(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in       (in_ch),
    .clr      (clr),
    .legal    (legal),
    .err      (err),
`ifdef EXPR_EVAL_EN
    .value    (value),
`endif
    .op_cnt   (op_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference: re-scan the accepted string since the last clear.
  // Even positions must be digits, odd positions operators; the first violation is sticky.
  function automatic void model(output bit m_legal, output bit m_err,
                                output int m_cnt, output int m_val);
    int unsigned sum = 0, term = 0;
    bit mul = 0;
    m_err = 0; m_cnt = 0; m_val = 0;
    for (int i = 0; i < q.size(); i++) begin
      byte unsigned c = q[i];
      bit isd = (c >= "0" && c <= "9");
      bit iso = (c == "+" || c == "*");
      if (i % 2 == 0) begin
        if (!isd) begin m_err = 1; break; end
        term  = mul ? (term * (c - 48)) & 16'hFFFF : (c - 48);
        m_val = int'((sum + term) & 16'hFFFF);
      end else begin
        if (!iso) begin m_err = 1; break; end
        m_cnt++;
        if (c == "+") begin sum = (sum + term) & 16'hFFFF; mul = 0; end
        else mul = 1;
      end
    end
    if (m_cnt > 255) m_cnt = 255;
    m_legal = !m_err && (q.size() % 2 == 1);
  endfunction

  task automatic check_all(input string tag);
    bit ml, me; int mc, mv;
    model(ml, me, mc, mv);
    chk({tag, ".legal"}, legal, ml);
    chk({tag, ".err"}, err, me);
    chk({tag, ".op_cnt"}, op_cnt, mc);
`ifdef EXPR_EVAL_EN
    chk({tag, ".value"}, value, mv);
`endif
  endtask

  task automatic step(input string tag, input logic v, input logic [7:0] c, input logic cl);
    @(negedge clk);
    in_valid = v; in_ch = c; clr = cl;
    @(posedge clk);
    #1;
    if (cl) q.delete();
    else if (v) q.push_back(c);
    in_valid = 1'b0; clr = 1'b0;
    check_all(tag);
  endtask

  initial begin
    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst.legal", legal, 0);
    chk("rst.err", err, 0);
    chk("rst.op_cnt", op_cnt, 0);
    @(negedge clk) rst_n = 1'b1;

    // 1+2*3
    step("t1a", 1, "1", 0); step("t1b", 1, "+", 0); step("t1c", 1, "2", 0);
    step("t1d", 1, "*", 0); step("t1e", 1, "3", 0);
    chk("t1.legal", legal, 1);
    chk("t1.op_cnt", op_cnt, 2);
`ifdef EXPR_EVAL_EN
    chk("t1.value", value, 7);
`endif
    // 7* then + -> sticky error
    step("t2clr", 0, "0", 1);
    step("t2a", 1, "7", 0); step("t2b", 1, "*", 0);
    chk("t2.mid_legal", legal, 0);
    step("t2c", 1, "+", 0);
    chk("t2.err", err, 1);
    step("t2d", 1, "4", 0);
    chk("t2.err_sticky", err, 1);
    // multi-digit operand, then clr
    step("t3clr", 0, "0", 1);
    step("t3a", 1, "1", 0); step("t3b", 1, "2", 0);
    chk("t3.err", err, 1);
    step("t3c", 0, "0", 1);
    chk("t3.clr_err", err, 0);
    // bad first char, idle cycles with "+" on the bus
    step("t4a", 1, 8'h61, 0);
    chk("t4.err", err, 1);
    step("t4clr", 0, "0", 1);
    step("t4b", 1, "3", 0);
    repeat (3) step("t4idle", 0, "+", 0);
    // clr together with a character
    step("t5a", 1, "5", 1);
    chk("t5.legal", legal, 0);
    // counter saturation
    for (int i = 0; i < 260; i++) begin
      step("t6d", 1, "1", 0);
      step("t6o", 1, "+", 0);
    end
    chk("t6.sat", op_cnt, 255);
    step("t6e", 1, "9", 0);
    // asynchronous reset between edges
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6.arst_legal", legal, 0);
    chk("t6.arst_err", err, 0);
    chk("t6.arst_cnt", op_cnt, 0);
`ifdef EXPR_EVAL_EN
    chk("t6.arst_val", value, 0);
`endif
    q.delete();
    @(negedge clk) rst_n = 1'b1;

    // random
    for (int n = 0; n < 2000; n++) begin
      int r = $urandom_range(0, 99);
      int s = $urandom_range(0, 19);
      logic [7:0] c;
      if (s == 0)      c = 8'($urandom_range(32, 126));
      else if (s == 1) c = (q.size() % 2 == 0) ? "+" : "5";
      else if (q.size() % 2 == 0) c = 8'("0" + $urandom_range(0, 9));
      else             c = ($urandom_range(0, 1) != 0) ? "*" : "+";
      step("rnd", (r >= 10), c, (r < 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
